// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with write-first bypass and a per-register pending-write scoreboard.
// Optional debug read port enabled by defining REGFILE_DBG_PORT_EN.
module regfile_mp #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NREAD  = 2,
   parameter int NWRITE = 1
) (
   input  logic                     clk,
   input  logic                     startin_n,
   input  logic [NREAD*ADDR_W-1:0]  rd_addr,
   output logic [NREAD*DATA_W-1:0]  rd_data,
   output logic [NREAD-1:0]         rd_busy,
   input  logic [NWRITE-1:0]        wr_en,
   input  logic [NWRITE*ADDR_W-1:0] wr_addr,
   input  logic [NWRITE*DATA_W-1:0] wr_data,
   input  logic                     rsv_en,
   input  logic [ADDR_W-1:0]        rsv_addr,
   output logic [ADDR_W:0]          pend_cnt
`ifdef REGFILE_DBG_PORT_EN
   ,
   input  logic [ADDR_W-1:0]        dbg_regNo,
   output logic [DATA_W-1:0]        dbg_val
`endif
);

   localparam int DEPTH = 1 << ADDR_W;

   // No stalls or handshakes: every write and reservation is accepted in the cycle it is presented.
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DEPTH-1:0]  busy;
   logic [DEPTH-1:0]  busy_nxt;
   logic [ADDR_W:0]   cnt_nxt;

   // Entry 0 is never written and its busy bit is never set, so it reads as 0 / not busy.
   for (genvar i = 0; i < NREAD; i++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] d;
      logic              b;

      assign ra = rd_addr[i*ADDR_W +: ADDR_W];

      always_comb begin
         d = mem[ra];
         b = busy[ra];
         for (int k = 0; k < NWRITE; k++) begin
            if (wr_en[k] && (ra != '0) && (wr_addr[k*ADDR_W +: ADDR_W] == ra)) begin
               d = wr_data[k*DATA_W +: DATA_W];
               b = 1'b0;
            end
         end
      end

      assign rd_data[i*DATA_W +: DATA_W] = d;
      assign rd_busy[i]                  = b;
   end

   // Reservation is applied after the write clears, so a same-cycle re-issue keeps the register pending.
   always_comb begin
      busy_nxt = busy;
      for (int k = 0; k < NWRITE; k++) begin
         if (wr_en[k]) begin
            busy_nxt[wr_addr[k*ADDR_W +: ADDR_W]] = 1'b0;
         end
      end
      if (rsv_en) begin
         busy_nxt[rsv_addr] = 1'b1;
      end
      busy_nxt[0] = 1'b0;

      cnt_nxt = '0;
      for (int j = 0; j < DEPTH; j++) begin
         cnt_nxt = cnt_nxt + {{ADDR_W{1'b0}}, busy_nxt[j]};
      end
   end

   // Later ports are assigned last, so the highest-index writer wins a same-address conflict.
   always_ff @(posedge clk) begin
      if (!startin_n) begin
         for (int j = 0; j < DEPTH; j++) begin
            mem[j] <= '0;
         end
         busy     <= '0;
         pend_cnt <= '0;
      end else begin
         for (int k = 0; k < NWRITE; k++) begin
            if (wr_en[k] && (wr_addr[k*ADDR_W +: ADDR_W] != '0)) begin
               mem[wr_addr[k*ADDR_W +: ADDR_W]] <= wr_data[k*DATA_W +: DATA_W];
            end
         end
         busy     <= busy_nxt;
         pend_cnt <= cnt_nxt;
      end
   end

`ifdef REGFILE_DBG_PORT_EN
   assign dbg_val = mem[dbg_regNo];
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp (NREAD=2, NWRITE=2): vector table plus hand-written multi-cycle sequences.
module tb_regfile_mp;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 2;
   localparam int NW = 2;

   logic              clk;
   logic              startin_n;
   logic [NR*AW-1:0]  rd_addr;
   logic [NR*DW-1:0]  rd_data;
   logic [NR-1:0]     rd_busy;
   logic [NW-1:0]     wr_en;
   logic [NW*AW-1:0]  wr_addr;
   logic [NW*DW-1:0]  wr_data;
   logic              rsv_en;
   logic [AW-1:0]     rsv_addr;
   logic [AW:0]       pend_cnt;

   regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR), .NWRITE(NW)) dut (
      .clk       (clk),
      .startin_n (startin_n),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .rd_busy   (rd_busy),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rsv_en    (rsv_en),
      .rsv_addr  (rsv_addr),
      .pend_cnt  (pend_cnt)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;
   logic [DW-1:0] exp_q[$];

   typedef struct {
      logic [AW-1:0] ra0;
      logic [AW-1:0] ra1;
      logic [NW-1:0] we;
      logic [AW-1:0] wa0;
      logic [DW-1:0] wd0;
      logic [AW-1:0] wa1;
      logic [DW-1:0] wd1;
      logic          rsv;
      logic [AW-1:0] rsva;
      logic [DW-1:0] d0;
      logic [DW-1:0] d1;
      logic          b0;
      logic          b1;
      logic [AW:0]   cnt;
   } vec_t;

   vec_t vt[8];

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr_en    = '0;
      wr_addr  = '0;
      wr_data  = '0;
      rsv_en   = 1'b0;
      rsv_addr = '0;
   endtask

   task automatic set_rd(input int p, input logic [AW-1:0] a);
      rd_addr[p*AW +: AW] = a;
   endtask

   task automatic set_wr(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
      wr_en[k]            = 1'b1;
      wr_addr[k*AW +: AW] = a;
      wr_data[k*DW +: DW] = d;
   endtask

   task automatic set_rsv(input logic [AW-1:0] a);
      rsv_en   = 1'b1;
      rsv_addr = a;
   endtask

   // scoreboard
   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic sb_push(input logic [DW-1:0] v);
      exp_q.push_back(v);
   endtask

   task automatic sb_check(input string name, input logic [DW-1:0] act);
      logic [DW-1:0] e;
      if (exp_q.size() == 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL %s: got %h, expected queue empty", name, act);
      end else begin
         e = exp_q.pop_front();
         check(name, act, e);
      end
   endtask

   task automatic read_chk(input string name, input int p, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic b);
      set_rd(p, a);
      sb_push(d);
      #1;
      sb_check({name, "_data"}, rd_data[p*DW +: DW]);
      check({name, "_busy"}, {31'd0, rd_busy[p]}, {31'd0, b});
   endtask

   initial begin
      // ra0 ra1 we wa0 wd0 wa1 wd1 rsv rsva | d0 d1 b0 b1 cnt(after edge)
      vt[0] = '{5'd1, 5'd2, 2'b01, 5'd1, 32'd100, 5'd0, 32'd0, 1'b1, 5'd2,
                32'd100, 32'd0, 1'b0, 1'b0, 6'd1};
      vt[1] = '{5'd1, 5'd2, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd2,
                32'd100, 32'd0, 1'b0, 1'b1, 6'd1};
      vt[2] = '{5'd2, 5'd3, 2'b10, 5'd0, 32'd0, 5'd2, 32'd200, 1'b1, 5'd3,
                32'd200, 32'd0, 1'b0, 1'b0, 6'd1};
      vt[3] = '{5'd3, 5'd2, 2'b11, 5'd3, 32'd300, 5'd3, 32'd301, 1'b0, 5'd0,
                32'd301, 32'd200, 1'b0, 1'b0, 6'd0};
      vt[4] = '{5'd0, 5'd31, 2'b01, 5'd31, 32'hA5A5A5A5, 5'd0, 32'd0, 1'b1, 5'd31,
                32'd0, 32'hA5A5A5A5, 1'b0, 1'b0, 6'd1};
      vt[5] = '{5'd31, 5'd1, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd30,
                32'hA5A5A5A5, 32'd100, 1'b1, 1'b0, 6'd2};
      vt[6] = '{5'd30, 5'd31, 2'b11, 5'd30, 32'd7, 5'd31, 32'd8, 1'b0, 5'd0,
                32'd7, 32'd8, 1'b0, 1'b0, 6'd0};
      vt[7] = '{5'd30, 5'd31, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0,
                32'd7, 32'd8, 1'b0, 1'b0, 6'd0};

      idle();
      rd_addr   = '0;
      startin_n = 1'b0;
      tick();
      tick();
      startin_n = 1'b1;

      // reset state
      check("rst_cnt", {26'd0, pend_cnt}, 32'd0);
      for (int a = 0; a < 32; a += 5) begin
         read_chk("rst_rd", a % 2, a[AW-1:0], 32'd0, 1'b0);
      end

      // table-driven vectors, starting from the reset state
      for (int v = 0; v < 8; v++) begin
         idle();
         set_rd(0, vt[v].ra0);
         set_rd(1, vt[v].ra1);
         if (vt[v].we[0]) set_wr(0, vt[v].wa0, vt[v].wd0);
         if (vt[v].we[1]) set_wr(1, vt[v].wa1, vt[v].wd1);
         if (vt[v].rsv) set_rsv(vt[v].rsva);
         sb_push(vt[v].d0);
         sb_push(vt[v].d1);
         #1;
         sb_check($sformatf("vec%0d_d0", v), rd_data[0 +: DW]);
         sb_check($sformatf("vec%0d_d1", v), rd_data[DW +: DW]);
         check($sformatf("vec%0d_b0", v), {31'd0, rd_busy[0]}, {31'd0, vt[v].b0});
         check($sformatf("vec%0d_b1", v), {31'd0, rd_busy[1]}, {31'd0, vt[v].b1});
         tick();
         check($sformatf("vec%0d_cnt", v), {26'd0, pend_cnt}, {26'd0, vt[v].cnt});
      end
      idle();

      // write r5 then read it next cycle
      set_wr(0, 5'd5, 32'hDEADBEEF);
      tick();
      idle();
      read_chk("r5_rd", 0, 5'd5, 32'hDEADBEEF, 1'b0);

      // same-cycle bypass on port 1, port 0 still sees stored r5
      set_wr(0, 5'd7, 32'h12345678);
      read_chk("byp_r7", 1, 5'd7, 32'h12345678, 1'b0);
      read_chk("byp_r5", 0, 5'd5, 32'hDEADBEEF, 1'b0);
      tick();
      idle();
      read_chk("r7_stored", 1, 5'd7, 32'h12345678, 1'b0);

      // scoreboard: reserve r3, not visible until next cycle
      set_rsv(5'd3);
      read_chk("rsv3_same", 0, 5'd3, 32'd301, 1'b0);
      tick();
      idle();
      check("rsv3_cnt", {26'd0, pend_cnt}, 32'd1);
      read_chk("rsv3_next", 0, 5'd3, 32'd301, 1'b1);
      set_wr(0, 5'd3, 32'd10);
      read_chk("wr3_same", 0, 5'd3, 32'd10, 1'b0);
      tick();
      idle();
      check("wr3_cnt", {26'd0, pend_cnt}, 32'd0);
      set_wr(0, 5'd3, 32'd20);
      set_rsv(5'd3);
      tick();
      idle();
      check("rw3_cnt", {26'd0, pend_cnt}, 32'd1);
      read_chk("rw3_after", 0, 5'd3, 32'd20, 1'b1);

      // zero register: write and reserve r0, count unchanged (r3 still pending)
      set_wr(0, 5'd0, 32'hFFFFFFFF);
      set_rsv(5'd0);
      read_chk("r0_same", 1, 5'd0, 32'd0, 1'b0);
      tick();
      idle();
      read_chk("r0_after", 1, 5'd0, 32'd0, 1'b0);
      check("r0_cnt", {26'd0, pend_cnt}, 32'd1);

      // write conflict: port 1 wins
      set_wr(0, 5'd9, 32'd1);
      set_wr(1, 5'd9, 32'd2);
      read_chk("wc_byp", 0, 5'd9, 32'd2, 1'b0);
      tick();
      idle();
      read_chk("wc_stored", 0, 5'd9, 32'd2, 1'b0);

      // two distinct clears in one cycle decrement by two
      set_rsv(5'd11);
      tick();
      set_rsv(5'd12);
      tick();
      set_rsv(5'd11);
      tick();
      idle();
      check("multi_rsv_cnt", {26'd0, pend_cnt}, 32'd3);
      set_wr(0, 5'd11, 32'd111);
      set_wr(1, 5'd12, 32'd112);
      tick();
      idle();
      check("multi_clr_cnt", {26'd0, pend_cnt}, 32'd1);

      // reset mid-operation overrides write and reservation
      startin_n = 1'b0;
      set_wr(0, 5'd4, 32'd55);
      set_rsv(5'd6);
      tick();
      idle();
      startin_n = 1'b1;
      check("mid_rst_cnt", {26'd0, pend_cnt}, 32'd0);
      read_chk("mid_rst_r4", 0, 5'd4, 32'd0, 1'b0);
      read_chk("mid_rst_r6", 1, 5'd6, 32'd0, 1'b0);
      read_chk("mid_rst_r3", 0, 5'd3, 32'd0, 1'b0);
      read_chk("mid_rst_r9", 1, 5'd9, 32'd0, 1'b0);
      tick();
      check("mid_rst_cnt2", {26'd0, pend_cnt}, 32'd0);

      // random writes/reads with a simple expected-value array
      begin
         logic [DW-1:0] model [32];
         logic [AW-1:0] a;
         logic [DW-1:0] d;
         for (int j = 0; j < 32; j++) model[j] = '0;
         for (int n = 0; n < 40; n++) begin
            a = AW'($urandom_range(0, 31));
            d = $urandom;
            set_wr(0, a, d);
            if (a != 0) model[a] = d;
            tick();
            idle();
            a = AW'($urandom_range(0, 31));
            read_chk("rand_rd", n % 2, a, model[a], 1'b0);
         end
      end

      if (exp_q.size() != 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL sb_drain: got %0d leftover entries, expected 0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
